// File: rtl/idecode_pkg.sv
// Shared decode definitions for the MIPS instruction-decode stage:
// opcodes, ALU class encoding and the ID/EX control bundle.
package idecode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    alu_op_t alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    reg_dst:    1'b0,
    alu_src:    1'b0,
    mem_to_reg: 1'b0,
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    branch:     1'b0,
    alu_op:     ALU_ADD
  };

  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = CTRL_BUBBLE;
    case (opcode)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      default: c = CTRL_BUBBLE;
    endcase
    return c;
  endfunction

  // rt is a source operand only for these formats; loads/addi write it instead
  function automatic logic rt_used(input logic [5:0] opcode);
    logic used;
    case (opcode)
      OP_RTYPE, OP_SW, OP_BEQ: used = 1'b1;
      default:                 used = 1'b0;
    endcase
    return used;
  endfunction

endpackage

// File: rtl/idecode_if.sv
// IF/ID, hazard, writeback and ID/EX signals of the decode stage.
// The slave side is the decode stage itself.
interface idecode_if #(
  parameter int PARAM_PC_WIDTH = 10
);
  logic [31:0]               ip_instruction;
  logic [PARAM_PC_WIDTH-1:0] ip_PC_plus_4;
  logic                      ip_flush;
  logic                      ip_ex_mem_read;
  logic [4:0]                ip_ex_rt;
  logic                      ip_wb_reg_write;
  logic [4:0]                ip_wb_write_reg;
  logic [31:0]               ip_wb_write_data;

  logic                      op_stall;
  logic [31:0]               op_read_data_1;
  logic [31:0]               op_read_data_2;
  logic [31:0]               op_sign_extend;
  logic [4:0]                op_rs;
  logic [4:0]                op_rt;
  logic [4:0]                op_rd;
  logic [PARAM_PC_WIDTH-1:0] op_PC_plus_4;
  logic                      op_reg_dst;
  logic                      op_alu_src;
  logic                      op_mem_to_reg;
  logic                      op_reg_write;
  logic                      op_mem_read;
  logic                      op_mem_write;
  logic                      op_branch;
  logic [1:0]                op_alu_op;

  modport master (
    output ip_instruction, ip_PC_plus_4, ip_flush, ip_ex_mem_read, ip_ex_rt,
           ip_wb_reg_write, ip_wb_write_reg, ip_wb_write_data,
    input  op_stall, op_read_data_1, op_read_data_2, op_sign_extend,
           op_rs, op_rt, op_rd, op_PC_plus_4, op_reg_dst, op_alu_src,
           op_mem_to_reg, op_reg_write, op_mem_read, op_mem_write,
           op_branch, op_alu_op
  );

  modport slave (
    input  ip_instruction, ip_PC_plus_4, ip_flush, ip_ex_mem_read, ip_ex_rt,
           ip_wb_reg_write, ip_wb_write_reg, ip_wb_write_data,
    output op_stall, op_read_data_1, op_read_data_2, op_sign_extend,
           op_rs, op_rt, op_rd, op_PC_plus_4, op_reg_dst, op_alu_src,
           op_mem_to_reg, op_reg_write, op_mem_read, op_mem_write,
           op_branch, op_alu_op
  );
endinterface

// File: rtl/idecode_reg_file.sv
// 2-read/1-write register file; reset loads reg[i]=i, $0 is hardwired to zero,
// and a same-cycle writeback is forwarded to the read ports.
module idecode_reg_file #(
  parameter int PARAM_NUM_REGS = 32,
  parameter int ADDR_W         = $clog2(PARAM_NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [31:0]       rd_data_1,
  output logic [31:0]       rd_data_2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [31:0] regs_r [PARAM_NUM_REGS];
  logic        wr_commit_s;

  assign wr_commit_s = wr_en && (wr_addr != ADDR_ZERO);

  // Storage: reset has priority over a writeback in the same cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < PARAM_NUM_REGS; i++) begin
        regs_r[i] <= 32'(i);
      end
    end else if (wr_commit_s) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Read ports with write-first forwarding and $0 forced to zero
  always_comb begin
    rd_data_1 = 32'd0;
    rd_data_2 = 32'd0;
    if (rd_addr_1 == ADDR_ZERO) begin
      rd_data_1 = 32'd0;
    end else if (wr_commit_s && (wr_addr == rd_addr_1)) begin
      rd_data_1 = wr_data;
    end else begin
      rd_data_1 = regs_r[rd_addr_1];
    end
    if (rd_addr_2 == ADDR_ZERO) begin
      rd_data_2 = 32'd0;
    end else if (wr_commit_s && (wr_addr == rd_addr_2)) begin
      rd_data_2 = wr_data;
    end else begin
      rd_data_2 = regs_r[rd_addr_2];
    end
  end

endmodule

// File: rtl/idecode.sv
// MIPS instruction-decode stage: register read, immediate extension, main
// control, load-use hazard detection and the ID/EX pipeline register.
module idecode
  import idecode_pkg::*;
#(
  parameter int PARAM_NUM_REGS = 32,
  parameter int PARAM_PC_WIDTH = 10
) (
  input  logic       clock,
  input  logic       reset,
  idecode_if.slave   bus
);

  localparam int ADDR_W = $clog2(PARAM_NUM_REGS);

  logic [5:0]                opcode_s;
  logic [4:0]                rs_s;
  logic [4:0]                rt_s;
  logic [4:0]                rd_s;
  logic [31:0]               imm_ext_s;
  logic [31:0]               rdata_1_s;
  logic [31:0]               rdata_2_s;
  ctrl_t                     ctrl_s;
  logic                      hazard_s;

  ctrl_t                     ctrl_r;
  logic [31:0]               rdata_1_r;
  logic [31:0]               rdata_2_r;
  logic [31:0]               imm_ext_r;
  logic [4:0]                rs_r;
  logic [4:0]                rt_r;
  logic [4:0]                rd_r;
  logic [PARAM_PC_WIDTH-1:0] pc_plus_4_r;

  assign opcode_s  = bus.ip_instruction[31:26];
  assign rs_s      = bus.ip_instruction[25:21];
  assign rt_s      = bus.ip_instruction[20:16];
  assign rd_s      = bus.ip_instruction[15:11];
  assign imm_ext_s = {{16{bus.ip_instruction[15]}}, bus.ip_instruction[15:0]};

  idecode_reg_file #(
    .PARAM_NUM_REGS (PARAM_NUM_REGS),
    .ADDR_W         (ADDR_W)
  ) u_reg_file (
    .clock     (clock),
    .reset     (reset),
    .rd_addr_1 (rs_s[ADDR_W-1:0]),
    .rd_addr_2 (rt_s[ADDR_W-1:0]),
    .rd_data_1 (rdata_1_s),
    .rd_data_2 (rdata_2_s),
    .wr_en     (bus.ip_wb_reg_write),
    .wr_addr   (bus.ip_wb_write_reg[ADDR_W-1:0]),
    .wr_data   (bus.ip_wb_write_data)
  );

  // Main control decode and load-use hazard detection
  always_comb begin
    ctrl_s   = decode_ctrl(opcode_s);
    hazard_s = 1'b0;
    if (bus.ip_ex_mem_read && (bus.ip_ex_rt != 5'd0)) begin
      hazard_s = (bus.ip_ex_rt == rs_s) || (rt_used(opcode_s) && (bus.ip_ex_rt == rt_s));
    end else begin
      hazard_s = 1'b0;
    end
  end

  // A taken branch redirects fetch anyway, so it overrides the stall
  assign bus.op_stall = hazard_s && !bus.ip_flush;

  // ID/EX register: reset and bubbles both clear every field
  always_ff @(posedge clock) begin
    if (reset || bus.ip_flush || hazard_s) begin
      ctrl_r      <= CTRL_BUBBLE;
      rdata_1_r   <= 32'd0;
      rdata_2_r   <= 32'd0;
      imm_ext_r   <= 32'd0;
      rs_r        <= 5'd0;
      rt_r        <= 5'd0;
      rd_r        <= 5'd0;
      pc_plus_4_r <= {PARAM_PC_WIDTH{1'b0}};
    end else begin
      ctrl_r      <= ctrl_s;
      rdata_1_r   <= rdata_1_s;
      rdata_2_r   <= rdata_2_s;
      imm_ext_r   <= imm_ext_s;
      rs_r        <= rs_s;
      rt_r        <= rt_s;
      rd_r        <= rd_s;
      pc_plus_4_r <= bus.ip_PC_plus_4;
    end
  end

  assign bus.op_read_data_1 = rdata_1_r;
  assign bus.op_read_data_2 = rdata_2_r;
  assign bus.op_sign_extend = imm_ext_r;
  assign bus.op_rs          = rs_r;
  assign bus.op_rt          = rt_r;
  assign bus.op_rd          = rd_r;
  assign bus.op_PC_plus_4   = pc_plus_4_r;
  assign bus.op_reg_dst     = ctrl_r.reg_dst;
  assign bus.op_alu_src     = ctrl_r.alu_src;
  assign bus.op_mem_to_reg  = ctrl_r.mem_to_reg;
  assign bus.op_reg_write   = ctrl_r.reg_write;
  assign bus.op_mem_read    = ctrl_r.mem_read;
  assign bus.op_mem_write   = ctrl_r.mem_write;
  assign bus.op_branch      = ctrl_r.branch;
  assign bus.op_alu_op      = ctrl_r.alu_op;

endmodule

// File: tb/tb_idecode.sv
// Self-checking bench for idecode: directed test-plan steps followed by
// randomized traffic, all checked against a behavioural register/decode model.
module tb_idecode;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  logic [31:0] mregs [32];

  idecode_if #(.PARAM_PC_WIDTH(10)) bus ();

  idecode #(
    .PARAM_NUM_REGS (32),
    .PARAM_PC_WIDTH (10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic flush, input logic ex_mr,
                       input logic [4:0] ex_rt, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd);
    bus.ip_instruction   = instr;
    bus.ip_PC_plus_4     = 10'($urandom_range(0, 1023));
    bus.ip_flush         = flush;
    bus.ip_ex_mem_read   = ex_mr;
    bus.ip_ex_rt         = ex_rt;
    bus.ip_wb_reg_write  = we;
    bus.ip_wb_write_reg  = wr;
    bus.ip_wb_write_data = wd;
  endtask

  // One clock of the stage: check the stall, clock it, then check ID/EX against the model
  task automatic step(input string tag);
    logic [31:0] ins, wd, e_rd1, e_rd2, e_se;
    logic [5:0]  opc;
    logic [4:0]  rs, rt, rd, ex_rt, wr;
    logic [9:0]  pc;
    logic        is_r, is_lw, is_sw, is_beq, is_addi, uses_rt, haz, flush, we, rst, bubble;
    logic [1:0]  e_alu;
    logic [8:0]  e_ctrl, o_ctrl;
    #1;
    ins = bus.ip_instruction; pc = bus.ip_PC_plus_4; flush = bus.ip_flush;
    ex_rt = bus.ip_ex_rt; we = bus.ip_wb_reg_write; wr = bus.ip_wb_write_reg;
    wd = bus.ip_wb_write_data; rst = reset;
    opc = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    is_r = (opc == 6'h00); is_lw = (opc == 6'h23); is_sw = (opc == 6'h2B);
    is_beq = (opc == 6'h04); is_addi = (opc == 6'h08);
    uses_rt = is_r || is_sw || is_beq;
    haz = bus.ip_ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == rs) || (uses_rt && ex_rt == rt));
    chk($sformatf("%s.stall", tag), 32'(bus.op_stall), 32'(haz && !flush));
    e_rd1 = (rs == 5'd0) ? 32'd0 : ((we && wr == rs) ? wd : mregs[rs]);
    e_rd2 = (rt == 5'd0) ? 32'd0 : ((we && wr == rt) ? wd : mregs[rt]);
    e_se  = 32'($signed(ins[15:0]));
    e_alu = is_r ? 2'b10 : (is_beq ? 2'b01 : 2'b00);
    e_ctrl = {is_r, is_lw || is_sw || is_addi, is_lw, is_r || is_lw || is_addi,
              is_lw, is_sw, is_beq, e_alu};
    bubble = rst || flush || haz;
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'(i);
    end else if (we && wr != 5'd0) begin
      mregs[wr] = wd;
    end
    #1;
    o_ctrl = {bus.op_reg_dst, bus.op_alu_src, bus.op_mem_to_reg, bus.op_reg_write,
              bus.op_mem_read, bus.op_mem_write, bus.op_branch, bus.op_alu_op};
    chk($sformatf("%s.ctrl", tag), 32'(o_ctrl), bubble ? 32'd0 : 32'(e_ctrl));
    chk($sformatf("%s.rd1", tag), bus.op_read_data_1, bubble ? 32'd0 : e_rd1);
    chk($sformatf("%s.rd2", tag), bus.op_read_data_2, bubble ? 32'd0 : e_rd2);
    chk($sformatf("%s.sext", tag), bus.op_sign_extend, bubble ? 32'd0 : e_se);
    chk($sformatf("%s.fields", tag), 32'({bus.op_rs, bus.op_rt, bus.op_rd}),
        bubble ? 32'd0 : 32'({rs, rt, rd}));
    chk($sformatf("%s.pc", tag), 32'(bus.op_PC_plus_4), bubble ? 32'd0 : 32'(pc));
  endtask

  initial begin
    logic [31:0] ins;
    logic [5:0]  opcs [6];
    logic [4:0]  ex_rt;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    opcs[0] = 6'h00; opcs[1] = 6'h23; opcs[2] = 6'h2B;
    opcs[3] = 6'h04; opcs[4] = 6'h08; opcs[5] = 6'h3F;

    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    step("rst0");
    step("rst1");
    reset = 1'b0;

    drive(32'h01220820, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    step("add");
    chk("add.rd1_const", bus.op_read_data_1, 32'd9);
    chk("add.rd2_const", bus.op_read_data_2, 32'd2);

    drive(32'h2001FFFC, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    step("addi");
    chk("addi.sext_const", bus.op_sign_extend, 32'hFFFFFFFC);

    drive(32'h01220820, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h55555555);
    step("bypass");
    chk("bypass.rd1_const", bus.op_read_data_1, 32'h55555555);
    drive(32'h01220820, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    step("after_wr");

    drive(32'h00000820, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    step("wr_r0");
    chk("wr_r0.rd1_const", bus.op_read_data_1, 32'd0);

    drive(32'h01220820, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    #1;
    chk("hazard.stall_const", 32'(bus.op_stall), 32'd1);
    step("hazard");
    drive(32'h20090005, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    step("no_hazard");

    drive(32'h01220820, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    step("flush_haz");

    drive(32'h01220820, 1'b0, 1'b1, 5'd9, 1'b1, 5'd2, 32'h00001234);
    step("haz_wr");
    drive(32'h01220820, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    step("haz_wr_chk");

    drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    step("wr5");
    reset = 1'b1;
    drive(32'h00A00820, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'h11111111);
    step("mid_rst");
    reset = 1'b0;
    drive(32'h00A00820, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    step("post_rst");
    chk("post_rst.rd1_const", bus.op_read_data_1, 32'd5);

    for (int n = 0; n < 400; n++) begin
      ins = $urandom();
      ins[31:26] = opcs[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0) ins[31:26] = 6'($urandom());
      case ($urandom_range(0, 2))
        0:       ex_rt = ins[25:21];
        1:       ex_rt = ins[20:16];
        default: ex_rt = 5'($urandom());
      endcase
      reset = ($urandom_range(0, 99) == 0);
      drive(ins, ($urandom_range(0, 9) == 0), 1'($urandom()), ex_rt,
            1'($urandom()), 5'($urandom()), $urandom());
      step($sformatf("rnd%0d", n));
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/idecode.md
# idecode

Instruction-decode stage of the pipelined MIPS core, and the consumer of the IF/ID pipeline register. Each cycle it takes the fetched instruction and its PC+4, reads the 32×32 register file, sign-extends the immediate, and generates main control. It also detects load-use hazards, driving the fetch stall, and inserts bubbles into the ID/EX register on a stall or a taken-branch flush. Writeback from the WB stage lands here.

## Interface
Parameters:
- PARAM_NUM_REGS, 32, register-file depth (address width $clog2 = 5)
- PARAM_PC_WIDTH, 10, PC width, matching fetch

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- ip_instruction  in  32  instruction from IF/ID
- ip_PC_plus_4  in  10  PC+4 from IF/ID
- ip_flush  in  1  taken branch resolved in EX (zero && branch)
- ip_ex_mem_read  in  1  instruction now in EX is a load
- ip_ex_rt  in  5  destination (rt) of the instruction in EX
- ip_wb_reg_write  in  1  writeback enable
- ip_wb_write_reg  in  5  writeback register
- ip_wb_write_data  in  32  writeback data
- op_stall  out  1  to fetch; holds PC and IF/ID (combinational)
- op_read_data_1, op_read_data_2  out  32  registered rs/rt values
- op_sign_extend  out  32  registered sign-extended imm[15:0]
- op_rs, op_rt, op_rd  out  5 each  registered register fields
- op_PC_plus_4  out  10  registered PC+4
- op_reg_dst, op_alu_src, op_mem_to_reg, op_reg_write, op_mem_read, op_mem_write, op_branch  out  1 each  registered control
- op_alu_op  out  2  registered ALU class: 00 add, 01 sub (beq), 10 funct

## Operation
- Decode by opcode [31:26]:
  - 0x00 R-type: reg_dst, reg_write, alu_op=10
  - 0x23 LW: alu_src, mem_to_reg, reg_write, mem_read, alu_op=00
  - 0x2B SW: alu_src, mem_write, alu_op=00
  - 0x04 BEQ: branch, alu_op=01
  - 0x08 ADDI: alu_src, reg_write, alu_op=00
  - any other opcode: all control 0
- Register file:
  - Reset loads reg[i]=i.
  - reg[0] reads 0 always; writes to it are ignored.
  - Write occurs at posedge when ip_wb_reg_write=1.
  - Read bypass: if WB is writing register r≠0 in the same cycle that decode reads r, the read returns ip_wb_write_data.
- rt_used is 1 for R-type, SW and BEQ; 0 otherwise.
- hazard = ip_ex_mem_read && ip_ex_rt≠0 && (ip_ex_rt==rs || (rt_used && ip_ex_rt==rt)).
- op_stall = hazard && !ip_flush.
- ID/EX register update, in priority order:
  1. reset: all outputs 0.
  2. ip_flush or hazard: bubble; all control 0, data fields 0.
  3. otherwise: load decoded values.

## Timing
- Reset value of every registered output is 0. Register-file contents become reg[i]=i one cycle after reset is asserted.
- Decode-to-output latency: 1 cycle.
- op_stall is combinational in the same cycle as the hazard and lasts exactly one cycle per load-use pair. On the next cycle the load has moved to MEM, and fetch re-presents the held instruction.
- Flush and hazard together: a bubble is inserted and op_stall=0, because the branch wins at fetch as well.
- Writeback to a register during reset is discarded; reset has priority.
- A WB write and a hazard in the same cycle: the write still commits.

## Structure
- Package idecode_pkg:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI)
  - alu_op enum
  - packed struct ctrl_t holding the nine control bits, plus a zero-valued CTRL_BUBBLE constant
- Sub-module reg_file: 2 read ports, 1 write port, reset-to-index, write-first bypass.
- Top level holds the decoder, hazard logic and ID/EX register.

## Test plan
- Reset, then present 0x01220820 (add $1,$9,$2) → next cycle: read_data_1=9, read_data_2=2, reg_dst=1, reg_write=1, alu_op=10, rd=1.
- Present 0x2001FFFC (addi $1,$0,-4) → sign_extend=0xFFFFFFFC, alu_src=1, reg_write=1.
- WB writes $9=0x55555555 while decode reads $9 → read_data_1=0x55555555 in the same cycle (bypass); writing $0 leaves read=0.
- ip_ex_mem_read=1, ip_ex_rt=9, instruction add $1,$9,$2 → op_stall=1 for 1 cycle and ID/EX control all 0. Repeat with ip_ex_rt=9 and instruction addi $9,$0,5 (rt not a source) → no stall.
- ip_flush=1 together with the hazard above → op_stall=0 and ID/EX bubble.
- Assert reset mid-stream after writing $5=0xDEADBEEF → all outputs 0; $5 reads 5 afterward.
